// File: rtl/memory_io.sv
// memory_io: CPU data-memory decoder with RAM, screen shadow plus screen
// write FIFO toward the display controller, and a keyboard register.
// Optional build macro MEMORY_IO_ERR_EN enables the sticky illegal-write flag.
module memory_io #(
  parameter int RAM_AW     = 14,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_ovf,
  output logic        err
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PW + 1;

  logic [15:0] ram    [2**RAM_AW];
  logic [15:0] shadow [8192];
  logic [28:0] fifoMem [FIFO_DEPTH];

  logic [PW-1:0]    rdPtr, wrPtr;
  logic [CNT_W-1:0] count;
  logic [15:0]      kbdReg;
  logic             ovfReg;

  logic isRam, isScr, isKbd;
  logic wrRam, wrScr;
  logic full, push, pop, pushOk;

  // Address decode: RAM 0x0000-0x3FFF, screen 0x4000-0x5FFF, keyboard 0x6000.
  always_comb begin
    isRam  = (addressM[15:14] == 2'b00);
    isScr  = (addressM[15:13] == 3'b010);
    isKbd  = (addressM == 16'h6000);
    wrRam  = writeM && isRam && !reset;
    wrScr  = writeM && isScr && !reset;
    full   = (count == CNT_W'(FIFO_DEPTH));
    pop    = scr_valid && scr_ready;
    push   = wrScr;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    pushOk = push && (!full || pop);
  end

  // CPU read mux: pre-edge contents, unmapped reads return zero.
  always_comb begin
    inM = 16'h0000;
    if (isRam)      inM = ram[addressM[RAM_AW-1:0]];
    else if (isScr) inM = shadow[addressM[12:0]];
    else if (isKbd) inM = kbdReg;
  end

  // RAM and screen shadow are never cleared; writes during reset are ignored.
  always_ff @(posedge clk) begin
    if (wrRam) ram[addressM[RAM_AW-1:0]] <= outM;
    if (wrScr) shadow[addressM[12:0]]    <= outM;
  end

  // FIFO storage; when full with a same-edge pop, wrPtr equals rdPtr and the
  // departing head slot is reused.
  always_ff @(posedge clk) begin
    if (pushOk && !reset) fifoMem[wrPtr] <= {addressM[12:0], outM};
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr  <= '0;
      wrPtr  <= '0;
      count  <= '0;
      ovfReg <= 1'b0;
    end else begin
      if (pop)    rdPtr <= rdPtr + 1'b1;
      if (pushOk) wrPtr <= wrPtr + 1'b1;
      case ({pushOk, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !pushOk) ovfReg <= 1'b1;
    end
  end

  // Keyboard register follows the scan-code strobe; CPU writes never reach it.
  always_ff @(posedge clk) begin
    if (reset)          kbdReg <= 16'h0000;
    else if (kbd_valid) kbdReg <= kbd_code;
  end

  assign scr_valid = (count != '0);
  assign scr_addr  = fifoMem[rdPtr][28:16];
  assign scr_data  = fifoMem[rdPtr][15:0];
  assign scr_ovf   = ovfReg;

`ifdef MEMORY_IO_ERR_EN
  logic errReg;

  // Sticky flag for any CPU write at or above the keyboard address.
  always_ff @(posedge clk) begin
    if (reset)                                errReg <= 1'b0;
    else if (writeM && addressM >= 16'h6000) errReg <= 1'b1;
  end

  assign err = errReg;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_io.sv
// Self-checking bench for memory_io. Reference model: plain arrays for the
// memories, a queue for the screen FIFO, scalars for keyboard/flags.
// Honours MEMORY_IO_ERR_EN the same way as the design.
module tb_memory_io;
  localparam int DEPTH = 4;
  localparam int RAMW  = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addressM = '0, outM = '0, kbd_code = '0;
  logic        writeM = 1'b0, kbd_valid = 1'b0, scr_ready = 1'b0;
  logic [15:0] inM, scr_data;
  logic [12:0] scr_addr;
  logic        scr_valid, scr_ovf, err;

  int checks = 0, failures = 0;

  // reference model state
  logic [15:0] ramM [RAMW];
  bit          ramK [RAMW];
  logic [15:0] scrM [8192];
  bit          scrK [8192];
  logic [28:0] q[$];
  logic [15:0] kbdM;
  bit          ovfM, errM;
`ifdef MEMORY_IO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  memory_io #(.RAM_AW(14), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM),
    .writeM(writeM), .inM(inM), .kbd_code(kbd_code), .kbd_valid(kbd_valid),
    .scr_valid(scr_valid), .scr_ready(scr_ready), .scr_addr(scr_addr),
    .scr_data(scr_data), .scr_ovf(scr_ovf), .err(err)
  );

  always #5 clk = ~clk;

  // Advance one clock: update model from the pre-edge inputs, then let the
  // DUT take the edge and settle.
  task automatic tick();
    int a;
    a = int'(addressM);
    if (reset) begin
      q.delete(); kbdM = 16'h0000; ovfM = 0; errM = 0;
    end else begin
      if (q.size() > 0 && scr_ready) void'(q.pop_front());
      if (kbd_valid) kbdM = kbd_code;
      if (writeM) begin
        if (a < 'h4000) begin
          ramM[a % RAMW] = outM; ramK[a % RAMW] = 1;
        end else if (a < 'h6000) begin
          scrM[a - 'h4000] = outM; scrK[a - 'h4000] = 1;
          if (q.size() < DEPTH) q.push_back({addressM[12:0], outM});
          else ovfM = 1;
        end else if (ERR_EN) errM = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  // Model read of the current address; known=0 if never written.
  function automatic logic [15:0] modelRead(input int a, output bit known);
    known = 1;
    if (a < 'h4000) begin known = ramK[a % RAMW]; return ramM[a % RAMW]; end
    if (a < 'h6000) begin known = scrK[a - 'h4000]; return scrM[a - 'h4000]; end
    if (a == 'h6000) return kbdM;
    return 16'h0000;
  endfunction

  task automatic idle();
    writeM = 0; kbd_valid = 0; reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; scr_ready = 1; tick(); tick();
    idle(); addressM = 16'h6000; #1;
    checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", scr_valid); end
    checks++; if (scr_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", scr_ovf); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (inM !== 16'h0000) begin failures++; $display("FAIL reset_kbd got=%h want=0000", inM); end
  endtask

  task automatic test_ram();
    addressM = 16'h0010; outM = 16'hAAAA; writeM = 1; tick();
    outM = 16'h1234; #1;
    checks++; if (inM !== 16'hAAAA) begin failures++; $display("FAIL ram_old got=%h want=aaaa", inM); end
    tick(); writeM = 0; #1;
    checks++; if (inM !== 16'h1234) begin failures++; $display("FAIL ram_new got=%h want=1234", inM); end
  endtask

  task automatic test_screen();
    scr_ready = 1; addressM = 16'h4001; outM = 16'hFFFF; writeM = 1;
    #1;
    checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL scr_pre_valid got=%b want=0", scr_valid); end
    tick(); writeM = 0; #1;
    checks++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0001 || scr_data !== 16'hFFFF) begin
      failures++; $display("FAIL scr_head got=%b/%h/%h want=1/0001/ffff", scr_valid, scr_addr, scr_data); end
    checks++; if (inM !== 16'hFFFF) begin failures++; $display("FAIL scr_shadow got=%h want=ffff", inM); end
    tick();
    checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL scr_popped got=%b want=0", scr_valid); end
  endtask

  task automatic test_overflow();
    scr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      addressM = 16'h4010 + 16'(i); outM = 16'h1000 + 16'(i); writeM = 1; tick();
    end
    writeM = 0; addressM = 16'h4014; #1;
    checks++; if (scr_ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", scr_ovf); end
    checks++; if (inM !== 16'h1004) begin failures++; $display("FAIL ovf_shadow got=%h want=1004", inM); end
    tick(); tick();
    checks++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0010 || scr_data !== 16'h1000) begin
      failures++; $display("FAIL ovf_stable got=%b/%h/%h want=1/0010/1000", scr_valid, scr_addr, scr_data); end
    scr_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (scr_valid !== 1'b1 || scr_addr !== 13'h0010 + 13'(i) || scr_data !== 16'h1000 + 16'(i)) begin
        failures++; $display("FAIL ovf_pop%0d got=%b/%h/%h want=1/%h/%h", i, scr_valid, scr_addr, scr_data, 13'h0010 + 13'(i), 16'h1000 + 16'(i)); end
      tick();
    end
    checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b want=0", scr_valid); end
  endtask

  task automatic test_keyboard();
    kbd_code = 16'h0083; kbd_valid = 1; tick(); kbd_valid = 0; kbd_code = 16'h0055;
    addressM = 16'h6000; outM = 16'h0001; writeM = 1; tick(); writeM = 0; #1;
    checks++; if (inM !== 16'h0083) begin failures++; $display("FAIL kbd_read got=%h want=0083", inM); end
    checks++; if (err !== ERR_EN) begin failures++; $display("FAIL kbd_err got=%b want=%b", err, ERR_EN); end
  endtask

  task automatic test_unmapped();
    addressM = 16'h7000; outM = 16'hBEEF; writeM = 1; tick(); writeM = 0; #1;
    checks++; if (inM !== 16'h0000) begin failures++; $display("FAIL unmapped_read got=%h want=0000", inM); end
    addressM = 16'h0010; #1;
    checks++; if (inM !== 16'h1234) begin failures++; $display("FAIL unmapped_noeffect got=%h want=1234", inM); end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    bit known;
    int sel;
    for (int n = 0; n < 400; n++) begin
      reset     = ($urandom_range(0, 99) < 2);
      scr_ready = $urandom_range(0, 2) != 0;
      writeM    = $urandom_range(0, 1);
      kbd_valid = ($urandom_range(0, 4) == 0);
      kbd_code  = 16'($urandom);
      outM      = 16'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 3)       addressM = 16'h0020 + 16'($urandom_range(0, 63));
      else if (sel == 3) addressM = 16'h3FF0 + 16'($urandom_range(0, 15));
      else if (sel < 8)  addressM = 16'h4100 + 16'($urandom_range(0, 15));
      else if (sel == 8) addressM = 16'h6000;
      else               addressM = 16'h6001 + 16'($urandom_range(0, 16'h9FFE));
      #1;
      exp = modelRead(int'(addressM), known);
      if (known) begin
        checks++; if (inM !== exp) begin failures++; $display("FAIL rnd_inM n=%0d a=%h got=%h want=%h", n, addressM, inM, exp); end
      end
      checks++; if (scr_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, scr_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if ({scr_addr, scr_data} !== q[0]) begin failures++; $display("FAIL rnd_head n=%0d got=%h want=%h", n, {scr_addr, scr_data}, q[0]); end
      end
      checks++; if (scr_ovf !== ovfM || err !== errM) begin failures++; $display("FAIL rnd_flags n=%0d got=%b%b want=%b%b", n, scr_ovf, err, ovfM, errM); end
      tick();
    end
    idle();
  endtask

  task automatic test_reset_inflight();
    scr_ready = 0;
    addressM = 16'h4002; outM = 16'h0A0A; writeM = 1; tick();
    addressM = 16'h4003; outM = 16'h0B0B; tick();
    writeM = 0; #1;
    checks++; if (scr_valid !== 1'b1) begin failures++; $display("FAIL inflight_pending got=%b want=1", scr_valid); end
    reset = 1; addressM = 16'h0010; outM = 16'hDEAD; writeM = 1; kbd_valid = 1; kbd_code = 16'h0077;
    tick(); idle(); addressM = 16'h6000; #1;
    checks++; if (scr_valid !== 1'b0) begin failures++; $display("FAIL inflight_valid got=%b want=0", scr_valid); end
    checks++; if (inM !== 16'h0000) begin failures++; $display("FAIL inflight_kbd got=%h want=0000", inM); end
    addressM = 16'h0010; #1;
    checks++; if (inM !== 16'h1234) begin failures++; $display("FAIL inflight_ram got=%h want=1234", inM); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_screen();
    test_overflow();
    test_keyboard();
    test_unmapped();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
